// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_sequencer_pkg                                               |
// | Purpose : Shared definitions for the fetch sequencer and its neighbours:    |
// |           opcode values, execute-class bounds, instruction register field   |
// |           positions, FSM state encoding and a decode helper.                |
// | Ports   : none (package)                                                    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package fetch_sequencer_pkg;

  // Instruction register field positions (IR[7:4] opcode, IR[3:0] operand)
  localparam int c_op_msb  = 7;
  localparam int c_op_lsb  = 4;
  localparam int c_arg_msb = 3;
  localparam int c_arg_lsb = 0;

  // Opcodes
  localparam logic [3:0] c_op_nop   = 4'h0;
  localparam logic [3:0] c_op_ex_lo = 4'h1;
  localparam logic [3:0] c_op_ex_hi = 4'hB;
  localparam logic [3:0] c_op_jmp   = 4'hC;
  localparam logic [3:0] c_op_jz    = 4'hD;
  localparam logic [3:0] c_op_jnz   = 4'hE;
  localparam logic [3:0] c_op_hlt   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // Opcodes handed to the datapath through the EX handshake
  function automatic logic is_ex_class(input logic [3:0] op);
    return (op >= c_op_ex_lo) && (op <= c_op_ex_hi);
  endfunction

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_sequencer_if                                                |
// | Purpose : Bundle of the sequencer's control/bus signals.                    |
// |           master = sequencer side, slave = ROM/datapath/system side.        |
// |           run      : start/resume request                                   |
// |           rom_addr : ROM address (= PC)     rom_data : ROM instruction word |
// |           ex_req/ex_op/ex_arg : execute request to datapath                 |
// |           ex_ack   : datapath done          zero : datapath zero flag       |
// |           halted / fault : status                                           |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface fetch_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              ex_req;
  logic [3:0]        ex_op;
  logic [3:0]        ex_arg;
  logic              ex_ack;
  logic              zero;
  logic              halted;
  logic              fault;

  modport master (
    input  run, rom_data, ex_ack, zero,
    output rom_addr, ex_req, ex_op, ex_arg, halted, fault
  );

  modport slave (
    output run, rom_data, ex_ack, zero,
    input  rom_addr, ex_req, ex_op, ex_arg, halted, fault
  );
endinterface : fetch_sequencer_if
`default_nettype wire

// File: rtl/pc_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pc_loadable                                                       |
// | Purpose : Program counter register with parallel load and increment.       |
// |           Load has priority over increment; increment wraps silently.       |
// | Ports   : clk, rst_n (async, active-low), inc, ld, d[ADDR_W], q[ADDR_W]     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pc_loadable #(
  parameter int ADDR_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              inc,
  input  wire logic              ld,
  input  wire logic [ADDR_W-1:0] d,
  output logic      [ADDR_W-1:0] q
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (ld) begin
      r_pc <= d;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign q = r_pc;

endmodule : pc_loadable
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_sequencer                                                   |
// | Purpose : Control unit sequencing PC and instruction ROM: fetch, decode,    |
// |           branch, hand execute-class ops to the datapath, halt, and fault   |
// |           on an execute acknowledge timeout.                                |
// | Ports   : clk, rst_n (async, active-low),                                   |
// |           bus (fetch_sequencer_if.master): run, rom_addr, rom_data,         |
// |           ex_req, ex_op, ex_arg, ex_ack, zero, halted, fault                |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int EX_TIMEOUT = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fetch_sequencer_if.master bus
);

  localparam int c_cnt_w = (EX_TIMEOUT > 1) ? $clog2(EX_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(EX_TIMEOUT - 1);

  state_t             r_state;
  logic [DATA_W-1:0]  r_ir;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ex_req;
  logic [3:0]         r_ex_op;
  logic [3:0]         r_ex_arg;
  logic               r_halted;
  logic               r_fault;

  logic [3:0]         w_op;
  logic [3:0]         w_arg;
  logic               w_taken;
  logic               w_pc_inc;
  logic               w_pc_ld;
  logic [ADDR_W-1:0]  w_pc;

  assign w_op  = r_ir[c_op_msb:c_op_lsb];
  assign w_arg = r_ir[c_arg_msb:c_arg_lsb];

  // Branch decision is made in EXEC using the live zero flag
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      c_op_jmp: w_taken = 1'b1;
      c_op_jz:  w_taken = bus.zero;
      c_op_jnz: w_taken = !bus.zero;
      default:  w_taken = 1'b0;
    endcase
  end

  assign w_pc_inc = (r_state == S_FETCH);
  assign w_pc_ld  = (r_state == S_EXEC) && w_taken;

  pc_loadable #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pc_inc),
    .ld    (w_pc_ld),
    .d     (ADDR_W'(w_arg)),
    .q     (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_ex_req <= 1'b0;
      r_ex_op  <= 4'h0;
      r_ex_arg <= 4'h0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir    <= bus.rom_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_op == c_op_hlt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (is_ex_class(w_op)) begin
            // Operands captured here so they stay stable for the whole WAIT
            r_state  <= S_WAIT;
            r_cnt    <= '0;
            r_ex_req <= 1'b1;
            r_ex_op  <= w_op;
            r_ex_arg <= w_arg;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_WAIT: begin
          // An acknowledge on the last allowed cycle still completes normally
          if (bus.ex_ack) begin
            r_state  <= S_FETCH;
            r_ex_req <= 1'b0;
          end else if (r_cnt == c_cnt_last) begin
            r_state  <= S_FAULT;
            r_ex_req <= 1'b0;
            r_fault  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HALT: begin
          if (bus.run) begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_addr = w_pc;
  assign bus.ex_req   = r_ex_req;
  assign bus.ex_op    = r_ex_op;
  assign bus.ex_arg   = r_ex_arg;
  assign bus.halted   = r_halted;
  assign bus.fault    = r_fault;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_sequencer                                                |
// | Purpose : Directed self-checking bench for fetch_sequencer with a ROM       |
// |           array and an execute responder with programmable ack delay.       |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] rom [16];
  int         ack_delay;   // -1 = never acknowledge
  int         req_cycles;
  logic       resp_ack;
  int         total;
  int         bad;

  fetch_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  fetch_sequencer #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .EX_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];
  assign bus.ex_ack   = resp_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: raises ack on the (ack_delay+1)-th cycle that ex_req is seen high
  initial begin
    resp_ack   = 1'b0;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.ex_req) begin
        resp_ack   = 1'b0;
        req_cycles = 0;
      end else begin
        resp_ack   = (ack_delay >= 0) && (req_cycles == ack_delay);
        req_cycles = req_cycles + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    bus.run  = 1'b0;
    bus.zero = 1'b0;
    rst_n    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    load_nops();
    ack_delay = -1;
    do_reset();
    total++; if (bus.rom_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0h want=0", bus.rom_addr); end
    total++; if (bus.ex_req !== 1'b0) begin bad++; $display("FAIL reset_ex_req got=%b want=0", bus.ex_req); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", bus.halted); end
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", bus.fault); end
    total++; if ({bus.ex_op, bus.ex_arg} !== 8'h00) begin bad++; $display("FAIL reset_ex_oparg got=%0h want=0", {bus.ex_op, bus.ex_arg}); end
    tick();  // RUN=0: stays idle
    total++; if (bus.rom_addr !== 4'd0) begin bad++; $display("FAIL idle_hold_addr got=%0h want=0", bus.rom_addr); end
    bus.run = 1'b1;
    tick();  // IDLE -> FETCH
    bus.run = 1'b0;
    total++; if (bus.rom_addr !== 4'd0) begin bad++; $display("FAIL start_fetch_addr got=%0h want=0", bus.rom_addr); end
    tick();  // FETCH done
    total++; if (bus.rom_addr !== 4'd1) begin bad++; $display("FAIL first_fetch_pc got=%0h want=1", bus.rom_addr); end
  endtask

  task automatic test_straight_line();
    logic [3:0] exp_addr [7] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    load_nops();
    rom[2] = 8'hF0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.run = 1'b0;
      total++; if (bus.rom_addr !== exp_addr[i]) begin bad++; $display("FAIL line_addr[%0d] got=%0h want=%0h", i, bus.rom_addr, exp_addr[i]); end
      if (i == 5) begin
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL line_halted_early got=%b want=0", bus.halted); end
      end
    end
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL line_halted got=%b want=1", bus.halted); end
    repeat (2) tick();
    total++; if (bus.halted !== 1'b1 || bus.rom_addr !== 4'd3) begin bad++; $display("FAIL halt_hold got=%b/%0h want=1/3", bus.halted, bus.rom_addr); end
    bus.run = 1'b1;
    tick();  // HALT -> FETCH
    bus.run = 1'b0;
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL resume_halted got=%b want=0", bus.halted); end
    tick();
    total++; if (bus.rom_addr !== 4'd4) begin bad++; $display("FAIL resume_pc got=%0h want=4", bus.rom_addr); end
  endtask

  task automatic test_exec_handshake();
    load_nops();
    rom[0] = 8'h35;
    ack_delay = 2;
    do_reset();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();  // FETCH
    total++; if (bus.ex_req !== 1'b0) begin bad++; $display("FAIL ex_req_in_exec got=%b want=0", bus.ex_req); end
    tick();  // EXEC -> WAIT
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.ex_req !== 1'b1 || bus.ex_op !== 4'h3 || bus.ex_arg !== 4'h5) begin
        bad++; $display("FAIL ex_wait[%0d] got req=%b op=%0h arg=%0h want 1/3/5", i, bus.ex_req, bus.ex_op, bus.ex_arg);
      end
      tick();
    end
    total++; if (bus.ex_req !== 1'b0 || bus.rom_addr !== 4'd1) begin bad++; $display("FAIL ex_done got req=%b addr=%0h want 0/1", bus.ex_req, bus.rom_addr); end
    tick();
    total++; if (bus.rom_addr !== 4'd2) begin bad++; $display("FAIL ex_next_fetch got=%0h want=2", bus.rom_addr); end
  endtask

  task automatic test_branches();
    load_nops();
    rom[0] = 8'hD5;
    rom[5] = 8'hE9;
    ack_delay = -1;
    do_reset();
    bus.zero = 1'b1;
    bus.run  = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();  // fetch D5
    total++; if (bus.rom_addr !== 4'd1) begin bad++; $display("FAIL jz_fetch_pc got=%0h want=1", bus.rom_addr); end
    tick();  // JZ taken
    total++; if (bus.rom_addr !== 4'd5) begin bad++; $display("FAIL jz_taken got=%0h want=5", bus.rom_addr); end
    repeat (2) tick();  // JNZ with zero=1 not taken
    total++; if (bus.rom_addr !== 4'd6) begin bad++; $display("FAIL jnz_not_taken got=%0h want=6", bus.rom_addr); end
    repeat (18) tick();  // NOPs 6..14
    total++; if (bus.rom_addr !== 4'd15) begin bad++; $display("FAIL walk_to_15 got=%0h want=f", bus.rom_addr); end
    tick();  // fetch at 15 wraps
    total++; if (bus.rom_addr !== 4'd0) begin bad++; $display("FAIL pc_wrap got=%0h want=0", bus.rom_addr); end
    bus.zero = 1'b0;
    tick();  // EXEC of NOP at 15 -> FETCH at 0
    repeat (2) tick();  // D5 with zero=0 not taken
    total++; if (bus.rom_addr !== 4'd1) begin bad++; $display("FAIL jz_not_taken got=%0h want=1", bus.rom_addr); end
  endtask

  task automatic test_jump_self();
    load_nops();
    rom[0] = 8'hC3;
    rom[3] = 8'hC3;
    do_reset();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (2) tick();
    total++; if (bus.rom_addr !== 4'd3) begin bad++; $display("FAIL jmp_target got=%0h want=3", bus.rom_addr); end
    repeat (2) tick();
    total++; if (bus.rom_addr !== 4'd3 || bus.fault !== 1'b0) begin bad++; $display("FAIL jmp_self got addr=%0h fault=%b want 3/0", bus.rom_addr, bus.fault); end
  endtask

  task automatic test_timeout();
    load_nops();
    rom[0] = 8'h35;
    ack_delay = -1;
    do_reset();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (2) tick();   // now in first WAIT cycle
    repeat (7) tick();   // eighth WAIT cycle
    total++; if (bus.fault !== 1'b0 || bus.ex_req !== 1'b1) begin bad++; $display("FAIL to_before got fault=%b req=%b want 0/1", bus.fault, bus.ex_req); end
    tick();
    total++; if (bus.fault !== 1'b1 || bus.ex_req !== 1'b0) begin bad++; $display("FAIL to_fault got fault=%b req=%b want 1/0", bus.fault, bus.ex_req); end
    bus.run = 1'b1;
    repeat (3) tick();
    bus.run = 1'b0;
    total++; if (bus.fault !== 1'b1 || bus.rom_addr !== 4'd1 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL fault_sticky got fault=%b addr=%0h halted=%b want 1/1/0", bus.fault, bus.rom_addr, bus.halted);
    end

    ack_delay = 7;   // ack on the eighth WAIT cycle
    do_reset();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (2) tick();
    repeat (8) tick();
    total++; if (bus.fault !== 1'b0 || bus.ex_req !== 1'b0 || bus.rom_addr !== 4'd1) begin
      bad++; $display("FAIL ack_last got fault=%b req=%b addr=%0h want 0/0/1", bus.fault, bus.ex_req, bus.rom_addr);
    end
    tick();
    total++; if (bus.rom_addr !== 4'd2) begin bad++; $display("FAIL ack_last_next got=%0h want=2", bus.rom_addr); end
  endtask

  task automatic test_reset_mid_wait();
    load_nops();
    rom[0] = 8'h35;
    ack_delay = -1;
    do_reset();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (2) tick();
    total++; if (bus.ex_req !== 1'b1) begin bad++; $display("FAIL mid_req_up got=%b want=1", bus.ex_req); end
    #2;
    rst_n = 1'b0;
    #1;   // still before the next clock edge
    total++; if (bus.ex_req !== 1'b0 || bus.rom_addr !== 4'd0) begin bad++; $display("FAIL async_reset got req=%b addr=%0h want 0/0", bus.ex_req, bus.rom_addr); end
    total++; if ({bus.ex_op, bus.ex_arg} !== 8'h00) begin bad++; $display("FAIL async_reset_op got=%0h want=0", {bus.ex_op, bus.ex_arg}); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++; if (bus.rom_addr !== 4'd0 || bus.ex_req !== 1'b0) begin bad++; $display("FAIL post_reset_idle got addr=%0h req=%b want 0/0", bus.rom_addr, bus.ex_req); end
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    total++; if (bus.rom_addr !== 4'd1) begin bad++; $display("FAIL restart_pc got=%0h want=1", bus.rom_addr); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    ack_delay = -1;
    rst_n     = 1'b0;
    bus.run   = 1'b0;
    bus.zero  = 1'b0;
    load_nops();
    test_reset();
    test_straight_line();
    test_exec_handshake();
    test_branches();
    test_jump_self();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_sequencer
`default_nettype wire
